// File: rtl/pipeline_snapshot_tx.sv
// pipeline_snapshot_tx
// Freezes up to NUM_CH pipeline-register channels on a start pulse. The frozen
// copy is then streamed as a framed byte sequence into a UART TX FIFO:
//   HEADER, then {channel id, data bytes LSB first} for each enabled channel,
//   then an optional XOR checksum byte.
// The sender stalls on FIFO-full and presents the same byte again once the
// FIFO has room.
// Optional feature macro: SNAPSHOT_CHECKSUM_EN adds the trailing XOR checksum
// byte. The checksum covers the channel ids and data bytes, not HEADER.
module pipeline_snapshot_tx #(
  parameter int          NUM_CH   = 4,
  parameter int          CH_WIDTH = 129,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [NUM_CH-1:0]            i_ch_mask,
  input  logic [NUM_CH*CH_WIDTH-1:0]   i_ch_data,
  input  logic                         i_tx_full,
  output logic                         o_tx_start,
  output logic [7:0]                   o_tx_data,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int BPC = (CH_WIDTH + 7) / 8;
  localparam int CIW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIW = (BPC > 1) ? $clog2(BPC) : 1;

`ifdef SNAPSHOT_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHID, S_DATA, S_CSUM, S_DONE} state_t;
  localparam state_t S_TAIL = S_CSUM;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CHID, S_DATA, S_DONE} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t                       state_q, state_d;
  logic [CIW-1:0]               chIdx_q, chIdx_d;
  logic [BIW-1:0]               byteIdx_q, byteIdx_d;
  logic [NUM_CH-1:0]            mask_q, mask_d;
  logic [NUM_CH*CH_WIDTH-1:0]   snap_q, snap_d;
  logic                         txStart_q, txStart_d;
  logic [7:0]                   txData_q, txData_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
`ifdef SNAPSHOT_CHECKSUM_EN
  logic [7:0]                   csum_q, csum_d;
`endif

  logic                         nextFound;
  logic [CIW-1:0]               nextIdx;
  int                           searchBase;
  logic [BPC*8-1:0]             chPad;
  logic [7:0]                   curByte;
  logic [7:0]                   chIdByte;

  // Find the lowest enabled channel after the current one (or from 0 in HDR)
  always_comb begin
    nextFound  = 1'b0;
    nextIdx    = '0;
    searchBase = (state_q == S_HDR) ? 0 : int'(chIdx_q) + 1;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (n >= searchBase && mask_q[n]) begin
        nextFound = 1'b1;
        nextIdx   = CIW'(n);
      end
    end
  end

  // Select the current data byte of the frozen channel, zero-padded above CH_WIDTH
  always_comb begin
    chPad                 = '0;
    chPad[CH_WIDTH-1:0]   = snap_q[int'(chIdx_q)*CH_WIDTH +: CH_WIDTH];
    curByte               = chPad[int'(byteIdx_q)*8 +: 8];
    chIdByte              = 8'(chIdx_q);
  end

  // Frame sequencer: next state, counters and the registered byte strobe
  always_comb begin
    state_d   = state_q;
    chIdx_d   = chIdx_q;
    byteIdx_d = byteIdx_q;
    mask_d    = mask_q;
    snap_d    = snap_q;
    txStart_d = 1'b0;
    txData_d  = 8'h00;
    busy_d    = (state_q != S_IDLE);
    done_d    = (state_q == S_DONE);
`ifdef SNAPSHOT_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          snap_d    = i_ch_data;
          mask_d    = i_ch_mask;
          chIdx_d   = '0;
          byteIdx_d = '0;
`ifdef SNAPSHOT_CHECKSUM_EN
          csum_d    = 8'h00;
`endif
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (!i_tx_full) begin
          txStart_d = 1'b1;
          txData_d  = HEADER;
          if (nextFound) begin
            chIdx_d = nextIdx;
            state_d = S_CHID;
          end else begin
            state_d = S_TAIL;
          end
        end
      end
      S_CHID: begin
        if (!i_tx_full) begin
          txStart_d = 1'b1;
          txData_d  = chIdByte;
`ifdef SNAPSHOT_CHECKSUM_EN
          csum_d    = csum_q ^ chIdByte;
`endif
          byteIdx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (!i_tx_full) begin
          txStart_d = 1'b1;
          txData_d  = curByte;
`ifdef SNAPSHOT_CHECKSUM_EN
          csum_d    = csum_q ^ curByte;
`endif
          if (byteIdx_q == BIW'(BPC - 1)) begin
            byteIdx_d = '0;
            if (nextFound) begin
              chIdx_d = nextIdx;
              state_d = S_CHID;
            end else begin
              state_d = S_TAIL;
            end
          end else begin
            byteIdx_d = byteIdx_q + 1'b1;
          end
        end
      end
`ifdef SNAPSHOT_CHECKSUM_EN
      S_CSUM: begin
        if (!i_tx_full) begin
          txStart_d = 1'b1;
          txData_d  = csum_q;
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE: begin
        chIdx_d   = '0;
        byteIdx_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, snapshot and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      chIdx_q   <= '0;
      byteIdx_q <= '0;
      mask_q    <= '0;
      snap_q    <= '0;
      txStart_q <= 1'b0;
      txData_q  <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SNAPSHOT_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      chIdx_q   <= chIdx_d;
      byteIdx_q <= byteIdx_d;
      mask_q    <= mask_d;
      snap_q    <= snap_d;
      txStart_q <= txStart_d;
      txData_q  <= txData_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SNAPSHOT_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign o_tx_start = txStart_q;
  assign o_tx_data  = txData_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: doc/pipeline_snapshot_tx.md
# pipeline_snapshot_tx

Parametrised pipeline-state dump engine for the MIPS debug path. On a start pulse it captures up to NUM_CH pipeline-register channels (IF/ID, ID/EX, EX/MEM, MEM/WB, or any other flat bus) in one cycle. It then streams the frozen copy as a framed byte sequence into the UART transmit FIFO, honouring the FIFO-full backpressure. It sits between the pipeline latches and the UART TX path, alongside the debugger.

## Interface
- NUM_CH, 4, number of snapshot channels (1..16).
- CH_WIDTH, 129, bit width of every channel; narrower sources are zero-extended by the instantiator.
- HEADER, 8'hA5, frame start byte.
- i_clk  in  1  system clock; all logic is rising-edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  request one dump; sampled only in IDLE.
- i_ch_mask  in  NUM_CH  channel enable; bit n selects channel n.
- i_ch_data  in  NUM_CH*CH_WIDTH  flat channel bus; channel n is bits [n*CH_WIDTH +: CH_WIDTH].
- i_tx_full  in  1  UART TX FIFO full; no byte may be issued while high.
- o_tx_start  out  1  one-cycle write strobe into the TX FIFO.
- o_tx_data  out  8  byte qualified by o_tx_start.
- o_busy  out  1  high from the cycle after start capture until the cycle o_done pulses, inclusive.
- o_done  out  1  one-cycle pulse after the last byte is issued.

## Operation
- BYTES_PER_CH = ceil(CH_WIDTH/8), computed at elaboration. Channel-id byte = channel index, zero-extended to 8 bits.
- IDLE with i_start=1: latch i_ch_data and i_ch_mask into snapshot registers, go to HDR. i_start in any other state is ignored. Later changes on the inputs do not affect the frame in progress.
- Frame order:
  - HEADER.
  - For each enabled channel in ascending index: CH_ID byte, then BYTES_PER_CH data bytes, least-significant byte first. Pad bits above CH_WIDTH in the last byte are 0.
  - CSUM byte (if configured), then DONE.
- States: IDLE → HDR → (CH_ID → DATA)* → CSUM → DONE → IDLE. From HDR or the last DATA byte, the FSM skips to the next set mask bit. If no further mask bit is set, it goes to CSUM, or to DONE when the checksum is compiled out.
- Byte issue rule: a byte-emitting state (HDR, CH_ID, DATA, CSUM) asserts o_tx_start with o_tx_data in any cycle where i_tx_full=0, then advances. If i_tx_full=1, it holds state and byte index, and o_tx_start stays 0. The same byte is re-presented once i_tx_full drops; no byte is lost or duplicated.
- Empty mask: frame is HEADER (+ CSUM = 8'h00), then DONE.
- Counters: channel index is $clog2(NUM_CH) bits wide, minimum 1; byte index is $clog2(BYTES_PER_CH) bits wide, minimum 1. Both reset to 0 at each new channel or frame.
- Reset, at any time including mid-frame: next edge gives IDLE, counters and snapshot cleared, and all outputs 0. A partial frame is abandoned, not completed.

## Timing
- Reset values: o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_done=0.
- Outputs are registered. o_tx_data is 8'h00 whenever o_tx_start=0.
- Latency: i_start high at edge k gives HEADER strobe at edge k+1 when the FIFO is not full.
- Throughput: at most one byte per cycle. An unstalled frame takes 1 + K*(1+BYTES_PER_CH) + C cycles, where K = popcount(mask) and C = 1 with the checksum, else 0.
- o_done pulses the cycle after the final strobe, with o_busy still high. IDLE is reached the following cycle, and a new i_start is accepted there.

## Configuration
- SNAPSHOT_CHECKSUM_EN defined: CSUM state is present. The checksum byte is the XOR of every byte after HEADER (channel ids and data), and is 8'h00 for an empty mask.
- Undefined: CSUM state and XOR accumulator are absent. The frame ends after the last data byte (or after HEADER), and DONE follows directly.

## Test plan
Checksum enabled, NUM_CH=4, CH_WIDTH=12 (BYTES_PER_CH=2), HEADER=8'hA5 for all scenarios.
- Single channel: mask=4'b0001, ch0=12'hABC, start at cycle 0 → strobes cycles 1–5 with A5,00,BC,0A,B6; o_done at cycle 6; o_busy cycles 1–6.
- Order/skip: mask=4'b1010, ch1=12'h123, ch3=12'hFFF → A5,01,23,01,03,FF,0F, then checksum 01^23^01^03^FF^0F=8'hD0.
- Backpressure: scenario 1 with i_tx_full=1 during cycles 2–4 → strobes A5 (cycle 1), 00,BC,0A,B6 at cycles 5–8; no strobes in cycles 2–4; o_done at cycle 9.
- Empty mask and ignore: mask=0 → A5,00, then o_done. A second i_start and changed i_ch_data mid-frame in scenario 1 → byte stream unchanged.
- Reset mid-frame: assert i_rst at cycle 3 of scenario 1 → all outputs 0 from cycle 4, no o_done. A new start afterwards produces the full scenario-1 stream.
- Compile without SNAPSHOT_CHECKSUM_EN: scenario 1 gives A5,00,BC,0A with o_done at cycle 5.
